// File: rtl/mod_red_pkg.sv
// mod_red_pkg: shared widths, index-width helper and pipe-stage record for the Barrett reducer
package mod_red_pkg;
    localparam int MR_Q_LEN   = 60;
    localparam int MR_K_PER_Q = 2;
    localparam int MR_TAG_W   = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                             valid;
        logic [MR_K_PER_Q*MR_Q_LEN-1:0]   c;
        logic [MR_Q_LEN-1:0]              q;
        logic [MR_Q_LEN:0]                mu;
        logic [MR_TAG_W-1:0]              tag;
    } stage_t;
endpackage

// File: rtl/mod_red_csub.sv
// mod_red_csub: two-step conditional subtract taking r < 3q down to r mod q, optional output register
module mod_red_csub #(
    parameter int W     = 60,
    parameter int TAG_W = 8,
    parameter int REG   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [W+1:0]     i_r,
    input  logic [W-1:0]     i_q,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [W-1:0]     o_t,
    output logic [TAG_W-1:0] o_tag
);
    logic [W+1:0] w_q1, w_q2;
    logic [W-1:0] w_t;

    assign w_q1 = {2'b00, i_q};
    assign w_q2 = {1'b0, i_q, 1'b0};
    assign w_t  = W'(i_r >= w_q2 ? i_r - w_q2 : i_r >= w_q1 ? i_r - w_q1 : i_r);

    if (REG != 0) begin : g_reg
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                o_valid <= 1'b0;
                o_t     <= '0;
                o_tag   <= '0;
            end else if (i_en) begin
                o_valid <= i_valid;
                o_t     <= w_t;
                o_tag   <= i_tag;
            end
    end else begin : g_comb
        assign o_valid = i_valid;
        assign o_t     = w_t;
        assign o_tag   = i_tag;
    end
endmodule

// File: rtl/mod_red_barrett_mc.sv
// mod_red_barrett_mc: stall-pipelined Barrett reduction C mod q with a runtime-loadable modulus table
module mod_red_barrett_mc
    import mod_red_pkg::*;
#(
    parameter int  Q_LEN   = MR_Q_LEN,
    parameter int  NUM_MOD = 4,
    parameter int  TAG_W   = MR_TAG_W,
    parameter int  FF_MUL  = 1,
    parameter int  FF_OUT  = 1,
    localparam int K       = MR_K_PER_Q * Q_LEN,
    localparam int IW      = idx_w(NUM_MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [Q_LEN-1:0] cfg_q,
    input  logic [Q_LEN:0]   cfg_mu,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_c,
    input  logic [IW-1:0]    in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_LEN-1:0] out_t,
    output logic [TAG_W-1:0] out_tag
);
    localparam int AW = 3*Q_LEN + TAG_W + 4;
    localparam int BW = 3*Q_LEN + TAG_W + 5;

    logic [Q_LEN-1:0] r_tq  [NUM_MOD];
    logic [Q_LEN:0]   r_tmu [NUM_MOD];
    stage_t           r_s0, r_s1;
    logic             w_en;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < NUM_MOD; i++) begin
                r_tq[i]  <= '0;
                r_tmu[i] <= '0;
            end
        end else if (cfg_we) begin
            r_tq[cfg_idx]  <= cfg_q;
            r_tmu[cfg_idx] <= cfg_mu;
        end

    // q and mu are captured at accept so later table writes cannot touch in-flight work
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else if (w_en) begin
            r_s0 <= '{valid: in_valid, c: in_c, q: r_tq[in_sel], mu: r_tmu[in_sel], tag: in_tag};
            r_s1 <= r_s0;
        end

    logic [Q_LEN:0]   w_q3_d;
    logic [AW-1:0]    w_a_d, w_a;
    logic             w_a_v;
    logic [Q_LEN+1:0] w_a_cl;
    logic [Q_LEN-1:0] w_a_q;
    logic [TAG_W-1:0] w_a_tag;
    logic [Q_LEN:0]   w_a_q3;

    assign w_q3_d = (Q_LEN+1)'(({{(Q_LEN+1){1'b0}}, r_s1.c[K-1:Q_LEN-1]}
                              * {{(Q_LEN+1){1'b0}}, r_s1.mu}) >> (Q_LEN+1));
    assign w_a_d  = {r_s1.valid, r_s1.c[Q_LEN+1:0], r_s1.q, r_s1.tag, w_q3_d};

    if (FF_MUL != 0) begin : g_ff1
        logic [AW-1:0] r_a;
        always_ff @(posedge clk or negedge rst)
            if (!rst) r_a <= '0;
            else if (w_en) r_a <= w_a_d;
        assign w_a = r_a;
    end else begin : g_nf1
        assign w_a = w_a_d;
    end

    assign {w_a_v, w_a_cl, w_a_q, w_a_tag, w_a_q3} = w_a;

    logic [Q_LEN+1:0] w_p_d;
    logic [BW-1:0]    w_b_d, w_b;
    logic             w_b_v;
    logic [Q_LEN+1:0] w_b_cl;
    logic [Q_LEN-1:0] w_b_q;
    logic [TAG_W-1:0] w_b_tag;
    logic [Q_LEN+1:0] w_b_p;

    // only the low Q_LEN+2 bits of q3*q are needed; the subtraction below wraps at that width
    assign w_p_d = (Q_LEN+2)'({1'b0, w_a_q3} * {2'b00, w_a_q});
    assign w_b_d = {w_a_v, w_a_cl, w_a_q, w_a_tag, w_p_d};

    if (FF_MUL != 0) begin : g_ff2
        logic [BW-1:0] r_b;
        always_ff @(posedge clk or negedge rst)
            if (!rst) r_b <= '0;
            else if (w_en) r_b <= w_b_d;
        assign w_b = r_b;
    end else begin : g_nf2
        assign w_b = w_b_d;
    end

    assign {w_b_v, w_b_cl, w_b_q, w_b_tag, w_b_p} = w_b;

    logic             r_r_v;
    logic [Q_LEN+1:0] r_r;
    logic [Q_LEN-1:0] r_r_q;
    logic [TAG_W-1:0] r_r_tag;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_r_v   <= 1'b0;
            r_r     <= '0;
            r_r_q   <= '0;
            r_r_tag <= '0;
        end else if (w_en) begin
            r_r_v   <= w_b_v;
            r_r     <= w_b_cl - w_b_p;
            r_r_q   <= w_b_q;
            r_r_tag <= w_b_tag;
        end

    logic             w_c_v;
    logic [Q_LEN-1:0] w_c_t;
    logic [TAG_W-1:0] w_c_tag;

    mod_red_csub #(.W(Q_LEN), .TAG_W(TAG_W), .REG(1)) u_csub (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_valid (r_r_v),
        .i_r     (r_r),
        .i_q     (r_r_q),
        .i_tag   (r_r_tag),
        .o_valid (w_c_v),
        .o_t     (w_c_t),
        .o_tag   (w_c_tag)
    );

    if (FF_OUT != 0) begin : g_out
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                out_valid <= 1'b0;
                out_t     <= '0;
                out_tag   <= '0;
            end else if (w_en) begin
                out_valid <= w_c_v;
                out_t     <= w_c_t;
                out_tag   <= w_c_tag;
            end
    end else begin : g_nout
        assign out_valid = w_c_v;
        assign out_t     = w_c_t;
        assign out_tag   = w_c_tag;
    end
endmodule

// File: tb/tb_mod_red_barrett_mc.sv
// tb_mod_red_barrett_mc: directed self-checking bench for the multi-modulus Barrett reducer
module tb_mod_red_barrett_mc;
    localparam int FF_MUL = 1;
    localparam int FF_OUT = 1;
    localparam int LAT    = 4 + 2*FF_MUL + FF_OUT;
    localparam logic [59:0] Q0 = 60'h882d43400000001;
    localparam logic [59:0] Q1 = 60'hffcf00000000001;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [1:0]   cfg_idx;
    logic [59:0]  cfg_q;
    logic [60:0]  cfg_mu;
    logic         in_valid;
    logic         in_ready;
    logic [119:0] in_c;
    logic [1:0]   in_sel;
    logic [7:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [59:0]  out_t;
    logic [7:0]   out_tag;

    mod_red_barrett_mc #(.FF_MUL(FF_MUL), .FF_OUT(FF_OUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_q     (cfg_q),
        .cfg_mu    (cfg_mu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_sel    (in_sel),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_t     (out_t),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_ret = 0;
    int          cyc = 0;
    logic        s_ov, s_ir, acc;
    logic [59:0] s_t, e_t;
    logic [7:0]  s_tag;
    logic [59:0] exp_t[$];
    logic [7:0]  exp_tag[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [60:0] mu_of(input logic [59:0] q);
        return 61'(((128'd1) << 120) / {68'd0, q});
    endfunction

    function automatic logic [119:0] sq(input logic [59:0] q);
        logic [119:0] m;
        m = {60'd0, q - 60'd1};
        return m * m;
    endfunction

    // one cycle: sample just after the falling edge, score retire/accept, return at next falling edge
    task automatic tick();
        #1;
        s_ov  = out_valid;
        s_ir  = in_ready;
        s_t   = out_t;
        s_tag = out_tag;
        acc   = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_ret++;
            if (exp_t.size() == 0) check("spurious_result", out_valid, 1'b0);
            else begin
                check("out_t", out_t, exp_t.pop_front());
                check("out_tag", out_tag, exp_tag.pop_front());
            end
        end
        if (acc) begin
            exp_t.push_back(e_t);
            exp_tag.push_back(in_tag);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic load(input logic [1:0] idx, input logic [59:0] q);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_q   = q;
        cfg_mu  = mu_of(q);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic send(input logic [119:0] c, input logic [1:0] sel, input logic [7:0] tag, input logic [59:0] et);
        int n = 0;
        in_valid = 1'b1;
        in_c     = c;
        in_sel   = sel;
        in_tag   = tag;
        e_t      = et;
        do begin tick(); n++; end while (!acc && n < 50);
        if (!acc) check("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int n = 0;
        do begin tick(); n++; end while (!s_ov && n < 30);
        if (!s_ov) check("out_valid_timeout", s_ov, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_t.size() != 0 && n < 60) begin tick(); n++; end
        if (exp_t.size() != 0) check("drain_left", exp_t.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        int n, c0, r0;
        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_q = '0; cfg_mu = '0;
        in_valid = 1'b0; in_c = '0; in_sel = '0; in_tag = '0; e_t = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_t", out_t, 60'd0);
        check("rst_out_tag", out_tag, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        load(2'd0, Q0);
        send({60'd0, Q0} + 120'd5, 2'd0, 8'hA5, 60'd5);
        n = 0;
        do begin tick(); n++; end while (!s_ov && n < 20);
        check("latency", n, LAT);
        drain();

        c0 = cyc;
        send(120'd0, 2'd0, 8'd1, 60'd0);
        send({60'd0, Q0 - 60'd1}, 2'd0, 8'd2, Q0 - 60'd1);
        send(sq(Q0), 2'd0, 8'd3, 60'd1);
        check("b2b_accept_cycles", cyc - c0, 3);
        wait_ov();
        tick();
        check("b2b_second", s_ov, 1'b1);
        tick();
        check("b2b_third", s_ov, 1'b1);
        tick();
        check("b2b_gap_after", s_ov, 1'b0);
        drain();

        load(2'd1, Q1);
        for (int i = 0; i < 8; i++)
            send(sq(i % 2 == 1 ? Q1 : Q0), 2'(i % 2), 8'(i), 60'd1);
        drain();

        r0 = n_ret;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++)
            send({60'd0, Q0} * 120'(i + 2) + 120'(i + 3), 2'd0, 8'(8'h10 + i), 60'(i + 3));
        in_valid = 1'b1;
        in_c     = sq(Q0);
        in_sel   = 2'd0;
        in_tag   = 8'h17;
        e_t      = 60'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_in_ready", s_ir, 1'b0);
            check("stall_accept", acc, 1'b0);
            check("stall_out_valid", s_ov, 1'b1);
            check("stall_out_t", s_t, 60'd3);
            check("stall_out_tag", s_tag, 8'h10);
        end
        out_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!acc && n < 20);
        check("stall_release_accept", acc, 1'b1);
        in_valid = 1'b0;
        drain();
        check("stall_retired", n_ret - r0, 8);

        cfg_we  = 1'b1;
        cfg_idx = 2'd0;
        cfg_q   = Q1;
        cfg_mu  = mu_of(Q1);
        send({60'd0, Q0} + 120'd5, 2'd0, 8'h50, 60'd5);
        cfg_we = 1'b0;
        send({60'd0, Q1} + 120'd9, 2'd0, 8'h51, 60'd9);
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send({60'd0, Q1} + 120'(i + 1), 2'd1, 8'(8'h60 + i), 60'(i + 1));
        wait_ov();
        #2;
        check("pre_rst_out_valid", out_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_out_t", out_t, 60'd0);
        check("async_rst_out_tag", out_tag, 8'd0);
        check("async_rst_in_ready", in_ready, 1'b1);
        exp_t.delete();
        exp_tag.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        r0 = n_ret;
        repeat (12) tick();
        check("no_stale_results", n_ret - r0, 0);
        load(2'd1, Q1);
        send({60'd0, Q1} + 120'd7, 2'd1, 8'h70, 60'd7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
